// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single-precision field widths, exponent bias,
// and a packed view of a single-precision float.
package fpu_pkg;

    localparam int unsigned FLOAT_BIAS  = 127;
    localparam int unsigned FLOAT_EXP_W = 8;
    localparam int unsigned FLOAT_MAN_W = 23;

    typedef struct packed {
        logic                   sign;
        logic [FLOAT_EXP_W-1:0] exp;
        logic [FLOAT_MAN_W-1:0] man;
    } float_t;

endpackage

// File: rtl/int_to_float.sv
// int_to_float: multi-cycle conversion of a signed 32-bit integer to an IEEE-754
// single-precision float, rounding to nearest even.
//
// Ports:
//   clk            system clock
//   reset_i        asynchronous, active-high reset
//   a_value_i      signed integer operand, sampled on the accepted strobe cycle
//   z_value_o      float result, held until the next completed conversion
//   exec_strobe_i  one-cycle start request, honoured only when idle
//   done_strobe_o  one-cycle pulse, z_value_o valid from this cycle on
//   busy_o         high whenever a conversion is in progress
module int_to_float
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_i,
    input  logic [31:0] a_value_i,
    output logic [31:0] z_value_o,
    input  logic        exec_strobe_i,
    output logic        done_strobe_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StUnpack,
        StNormalise,
        StRound,
        StPack,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            a_q, a_d;
    logic                   s_q, s_d;
    logic [31:0]            m_q, m_d;
    logic signed [8:0]      e_q, e_d;
    logic [FLOAT_MAN_W-1:0] mant_q, mant_d;  // hidden bit dropped; it is always 1
    logic [31:0]            z_q, z_d;
    logic                   done_q, done_d;

    // Rounding terms taken from the normalised magnitude.
    logic        guard, rnd, sticky, round_up;
    logic [24:0] mant_inc;
    logic [8:0]  exp_biased;
    float_t      packed_res;

    always_comb begin
        guard      = m_q[7];
        rnd        = m_q[6];
        sticky     = |m_q[5:0];
        round_up   = guard && (rnd || sticky || m_q[8]);
        mant_inc   = {1'b0, m_q[31:8]} + 25'd1;
        exp_biased = e_q + 9'(FLOAT_BIAS);

        packed_res.sign = s_q;
        packed_res.exp  = exp_biased[FLOAT_EXP_W-1:0];
        packed_res.man  = mant_q;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        s_d     = s_q;
        m_d     = m_q;
        e_d     = e_q;
        mant_d  = mant_q;
        z_d     = z_q;
        done_d  = done_q;

        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (exec_strobe_i) begin
                    a_d     = a_value_i;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                if (a_q == 32'd0) begin
                    z_d     = 32'd0;
                    state_d = StDone;
                end else begin
                    s_d     = a_q[31];
                    // -2^31 negates to 0x80000000, already the right magnitude.
                    m_d     = a_q[31] ? (~a_q + 32'd1) : a_q;
                    e_d     = 9'sd31;
                    state_d = StNormalise;
                end
            end
            StNormalise: begin
                if (m_q[31]) begin
                    state_d = StRound;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - 9'sd1;
                end
            end
            StRound: begin
                if (round_up) begin
                    if (mant_inc[24]) begin
                        // Carry out to 2^24: renormalise to 1.0 * 2^(e+1).
                        mant_d = '0;
                        e_d    = e_q + 9'sd1;
                    end else begin
                        mant_d = mant_inc[22:0];
                    end
                end else begin
                    mant_d = m_q[30:8];
                end
                state_d = StPack;
            end
            StPack: begin
                z_d     = packed_res;
                state_d = StDone;
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            s_q     <= 1'b0;
            m_q     <= '0;
            e_q     <= '0;
            mant_q  <= '0;
            z_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            s_q     <= s_d;
            m_q     <= m_d;
            e_q     <= e_d;
            mant_q  <= mant_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign z_value_o     = z_q;
    assign done_strobe_o = done_q;
    assign busy_o        = (state_q != StIdle);

endmodule
